// File: rtl/wg_sequencer.sv
// Run-time controller for the six-shape waveform generator datapath.
// Paces the generator phase counter with a programmable tick, accepts new
// shape/rate/amplitude settings over valid/ready and switches them only at a
// waveform-period boundary, and produces one registered, scaled DAC sample.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   run               level request: 1 = generate, 0 = stop at next boundary
//   wg_co             generator carry, high while phase count == 255
//   *_in              the six shape samples (DW bits each)
//   cfg_valid/ready   configuration handshake (ready is combinational)
//   cfg_sel/div/amp   shape select, tick period minus one, attenuation shift
//   wg_tick           phase-advance enable for the generator (combinational)
//   wave_out          registered scaled sample
//   active_sel        shape currently driving wave_out
//   period_done       one-clk pulse after each period boundary
//   busy              sequencer not idle
module wg_sequencer #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             wg_co,
  input  logic [DW-1:0]    recip_in,
  input  logic [DW-1:0]    square_in,
  input  logic [DW-1:0]    sine_in,
  input  logic [DW-1:0]    triangle_in,
  input  logic [DW-1:0]    fullrect_in,
  input  logic [DW-1:0]    halfrect_in,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_sel,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_amp,
  output logic             wg_tick,
  output logic [DW-1:0]    wave_out,
  output logic [2:0]       active_sel,
  output logic             period_done,
  output logic             busy
);

  localparam int unsigned SEL_W = 3;
  localparam int unsigned AMP_W = 2;
  localparam logic [DW-1:0] MID = DW'((2 ** (DW - 1)) - 1);

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [DIV_W-1:0] div;
    logic [AMP_W-1:0] amp;
  } cfg_t;

  localparam cfg_t RST_CFG = '{sel: SEL_W'(2), div: '0, amp: '0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             pend_q, pend_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  cfg_t             act_q, act_d;
  cfg_t             shd_q, shd_d;
  logic [DW-1:0]    wave_q, wave_d;
  logic             pdone_q;

  cfg_t             cfg_in_c;
  logic             tick_c;
  logic             bound_c;
  logic             xfer_c;
  logic [DW-1:0]    x_c;
  logic             mute_c;

  // Tick, period boundary and handshake qualifiers
  assign cfg_in_c = '{sel: cfg_sel, div: cfg_div, amp: cfg_amp};
  assign tick_c   = (state_q != IDLE) && (div_cnt_q == act_q.div);
  assign bound_c  = tick_c && wg_co;
  assign xfer_c   = cfg_valid && !pend_q;

  // Next state, divider and configuration registers
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    div_cnt_d = div_cnt_q;
    act_d     = act_q;
    shd_d     = shd_q;

    case (state_q)
      IDLE:    if (run) state_d = RUN;
      RUN:     if (!run) state_d = bound_c ? IDLE : DRAIN;
      // A renewed run request wins over a boundary so ticks never pause
      DRAIN: begin
        if (run)          state_d = RUN;
        else if (bound_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE || tick_c) div_cnt_d = '0;
    else                           div_cnt_d = div_cnt_q + DIV_W'(1);

    if (bound_c && pend_q) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end

    // xfer_c requires !pend_q, so it never collides with the shadow apply
    if (xfer_c) begin
      if (state_q == IDLE) begin
        act_d = cfg_in_c;
      end else begin
        shd_d  = cfg_in_c;
        pend_d = 1'b1;
      end
    end
  end

  // Shape mux and attenuation re-centred on midscale
  always_comb begin
    x_c    = MID;
    mute_c = 1'b0;
    case (act_q.sel)
      3'd0:    x_c = recip_in;
      3'd1:    x_c = square_in;
      3'd2:    x_c = sine_in;
      3'd3:    x_c = triangle_in;
      3'd4:    x_c = fullrect_in;
      3'd5:    x_c = halfrect_in;
      default: mute_c = 1'b1;
    endcase
    wave_d = DW'((x_c >> act_q.amp) + (MID - (MID >> act_q.amp)));
    if (state_q == IDLE || mute_c) wave_d = MID;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      div_cnt_q <= '0;
      act_q     <= RST_CFG;
      shd_q     <= '0;
      wave_q    <= MID;
      pdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      div_cnt_q <= div_cnt_d;
      act_q     <= act_d;
      shd_q     <= shd_d;
      wave_q    <= wave_d;
      pdone_q   <= bound_c;
    end
  end

  assign cfg_ready   = !pend_q;
  assign wg_tick     = tick_c;
  assign wave_out    = wave_q;
  assign active_sel  = act_q.sel;
  assign period_done = pdone_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_wg_sequencer.sv
// Directed bench for wg_sequencer: expected DAC samples go through a
// scoreboard queue, control outputs are checked against fixed expectations.
module tb_wg_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        wg_co;
  logic [7:0]  recip_in, square_in, sine_in, triangle_in, fullrect_in, halfrect_in;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_sel;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_amp;
  logic        wg_tick;
  logic [7:0]  wave_out;
  logic [2:0]  active_sel;
  logic        period_done;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];

  wg_sequencer #(.DW(8), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .wg_co(wg_co),
    .recip_in(recip_in), .square_in(square_in), .sine_in(sine_in),
    .triangle_in(triangle_in), .fullrect_in(fullrect_in), .halfrect_in(halfrect_in),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
    .cfg_div(cfg_div), .cfg_amp(cfg_amp), .wg_tick(wg_tick), .wave_out(wave_out),
    .active_sel(active_sel), .period_done(period_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_wave(input string tag);
    logic [7:0] e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: observed=%0d expected=<empty scoreboard>", tag, wave_out);
    end else begin
      e = sb.pop_front();
      chk(tag, 32'(wave_out), 32'(e));
    end
  endtask

  task automatic offer(input logic [2:0] s, input logic [15:0] d, input logic [1:0] a);
    cfg_valid = 1'b1;
    cfg_sel   = s;
    cfg_div   = d;
    cfg_amp   = a;
  endtask

  initial begin
    logic [7:0] v;
    rst = 1'b0; run = 1'b0; wg_co = 1'b0; cfg_valid = 1'b0;
    cfg_sel = 3'd0; cfg_div = 16'd0; cfg_amp = 2'd0;
    recip_in = 8'h11; square_in = 8'h22; sine_in = 8'h33;
    triangle_in = 8'h44; fullrect_in = 8'h55; halfrect_in = 8'h66;

    // Reset state
    #12;
    chk("rst_wave", 32'(wave_out), 32'd127);
    chk("rst_sel", 32'(active_sel), 32'd2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_tick", 32'(wg_tick), 32'd0);
    chk("rst_pdone", 32'(period_done), 32'd0);
    step();
    rst = 1'b1;

    // 1: sine, div 0 -> tick every clk, wave_out = sine delayed one clk
    run = 1'b1;
    step();
    chk("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_tick", 32'(wg_tick), 32'd1);
      v = 8'($urandom_range(0, 255));
      sine_in = v;
      sb.push_back(v);
      step();
      chk_wave("t1_wave");
    end

    // Stop on a boundary, then load div=3 while idle
    run = 1'b0; wg_co = 1'b1;
    step();
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_pdone", 32'(period_done), 32'd1);
    wg_co = 1'b0;
    step();
    chk("t1_idle_wave", 32'(wave_out), 32'd127);
    chk("t1_idle_pdone0", 32'(period_done), 32'd0);
    offer(3'd2, 16'd3, 2'd0);
    step();
    cfg_valid = 1'b0;
    chk("t2_ready_idle", 32'(cfg_ready), 32'd1);

    // 2: div 3, carry held high -> tick and period_done every 4 clk
    run = 1'b1; wg_co = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      chk("t2_tick", 32'(wg_tick), 32'((i % 4) == 3));
      chk("t2_pdone", 32'(period_done), 32'(((i % 4) == 0) && (i != 0)));
      if (i == 11) wg_co = 1'b0;
      step();
    end

    // 3: mid-period reconfiguration held in shadow until the boundary
    offer(3'd3, 16'd1, 2'd0);
    chk("t3_ready0", 32'(cfg_ready), 32'd1);
    step();
    chk("t3_pend_ready", 32'(cfg_ready), 32'd0);
    chk("t3_sel_hold", 32'(active_sel), 32'd2);
    offer(3'd5, 16'd0, 2'd0);
    step();
    chk("t3_stall_ready", 32'(cfg_ready), 32'd0);
    chk("t3_stall_sel", 32'(active_sel), 32'd2);
    wg_co = 1'b1;
    step();
    chk("t3_btick", 32'(wg_tick), 32'd1);
    chk("t3_pre_b_sel", 32'(active_sel), 32'd2);
    cfg_valid = 1'b0;
    step();
    chk("t3_post_sel", 32'(active_sel), 32'd3);
    chk("t3_post_ready", 32'(cfg_ready), 32'd1);
    chk("t3_post_pdone", 32'(period_done), 32'd1);
    chk("t3_newdiv_t0", 32'(wg_tick), 32'd0);
    wg_co = 1'b0;
    triangle_in = 8'hA5;
    sb.push_back(8'hA5);
    step();
    chk_wave("t3_tri_wave");
    chk("t3_newdiv_t1", 32'(wg_tick), 32'd1);

    // 5: drain behaviour
    run = 1'b0;
    step();
    chk("t5_drain_busy", 32'(busy), 32'd1);
    chk("t5_drain_t0", 32'(wg_tick), 32'd0);
    run = 1'b1;
    step();
    chk("t5_rerun_tick", 32'(wg_tick), 32'd1);
    chk("t5_rerun_busy", 32'(busy), 32'd1);
    run = 1'b0;
    step();
    chk("t5_drain2_busy", 32'(busy), 32'd1);
    step();
    chk("t5_drain2_tick", 32'(wg_tick), 32'd1);
    chk("t5_drain2_busy1", 32'(busy), 32'd1);
    wg_co = 1'b1;
    step();
    chk("t5_idle_busy", 32'(busy), 32'd0);
    chk("t5_idle_pdone", 32'(period_done), 32'd1);
    chk("t5_idle_tick", 32'(wg_tick), 32'd0);
    wg_co = 1'b0;
    step();
    chk("t5_idle_wave", 32'(wave_out), 32'd127);

    // 4: amplitude scaling; transfer on a boundary waits one more period
    offer(3'd1, 16'd0, 2'd1);
    step();
    cfg_valid = 1'b0;
    chk("t4_sel_direct", 32'(active_sel), 32'd1);
    chk("t4_ready", 32'(cfg_ready), 32'd1);
    run = 1'b1;
    step();
    square_in = 8'd255;
    sb.push_back(8'd191);
    step();
    chk_wave("t4_amp1_255");
    square_in = 8'd0;
    sb.push_back(8'd64);
    offer(3'd1, 16'd0, 2'd3);
    wg_co = 1'b1;
    step();
    chk_wave("t4_amp1_0");
    chk("t4_onb_ready", 32'(cfg_ready), 32'd0);
    chk("t4_onb_sel", 32'(active_sel), 32'd1);
    cfg_valid = 1'b0;
    square_in = 8'd255;
    sb.push_back(8'd191);
    step();
    chk_wave("t4_not_yet");
    chk("t4_apply_ready", 32'(cfg_ready), 32'd1);
    chk("t4_apply_pdone", 32'(period_done), 32'd1);
    sb.push_back(8'd143);
    wg_co = 1'b0;
    step();
    chk_wave("t4_amp3_255");
    offer(3'd6, 16'd0, 2'd0);
    step();
    chk("t4_mute_pend", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    wg_co = 1'b1;
    step();
    chk("t4_mute_sel", 32'(active_sel), 32'd6);
    wg_co = 1'b0;
    sb.push_back(8'd127);
    step();
    chk_wave("t4_mute_wave");
    chk("t4_mute_busy", 32'(busy), 32'd1);

    // 5: run dropped exactly on a boundary
    run = 1'b0; wg_co = 1'b1;
    step();
    chk("t5_onb_busy", 32'(busy), 32'd0);
    chk("t5_onb_pdone", 32'(period_done), 32'd1);
    wg_co = 1'b0;

    // 6: asynchronous reset while a shadow config is pending
    run = 1'b1;
    step();
    offer(3'd4, 16'd0, 2'd0);
    step();
    cfg_valid = 1'b0;
    chk("t6_pend", 32'(cfg_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_wave", 32'(wave_out), 32'd127);
    chk("t6_async_sel", 32'(active_sel), 32'd2);
    chk("t6_async_busy", 32'(busy), 32'd0);
    chk("t6_async_ready", 32'(cfg_ready), 32'd1);
    chk("t6_async_tick", 32'(wg_tick), 32'd0);
    run = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("t6_rel_sel", 32'(active_sel), 32'd2);
    chk("t6_rel_ready", 32'(cfg_ready), 32'd1);
    run = 1'b1; wg_co = 1'b1;
    step();
    step();
    chk("t6_no_apply_sel", 32'(active_sel), 32'd2);
    chk("t6_no_apply_pdone", 32'(period_done), 32'd1);
    run = 1'b0; wg_co = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
